// File: rtl/rng_pkg.sv
// rng_pkg: default LFSR tap masks and seeds for common widths.
package rng_pkg;
  localparam logic [3:0]  TAPS4  = 4'hC;
  localparam logic [3:0]  SEED4  = 4'hA;
  localparam logic [7:0]  TAPS8  = 8'hB8;
  localparam logic [7:0]  SEED8  = 8'hA5;
  localparam logic [15:0] TAPS16 = 16'hB400;
  localparam logic [15:0] SEED16 = 16'hACE1;
  localparam logic [31:0] TAPS32 = 32'h8020_0003;
  localparam logic [31:0] SEED32 = 32'hDEAD_BEEF;
endpackage

// File: rtl/lfsr_core.sv
// lfsr_core: left-shifting Fibonacci LFSR with seed load and lock-up recovery.
module lfsr_core import rng_pkg::*; #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = TAPS16,
  parameter logic [WIDTH-1:0] SEED  = SEED16,
  parameter int               OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [OUT_W-1:0] cand
);
  logic [WIDTH-1:0] state_d, state_q;
  always_comb begin
    state_d = state_q;
    if (seed_load) state_d = (seed == '0) ? SEED : seed;
    else if (en) state_d = (state_q == '0) ? SEED : {state_q[WIDTH-2:0], ^(state_q & TAPS)};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= SEED;
    else state_q <= state_d;
  assign cand = state_q[OUT_W-1:0];
endmodule

// File: rtl/lfsr_rng.sv
// lfsr_rng: LFSR random source with divided sampling, range rejection
// and a single-entry valid/ready output slot.
module lfsr_rng import rng_pkg::*; #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] TAPS       = TAPS16,
  parameter logic [WIDTH-1:0] SEED       = SEED16,
  parameter int               SAMPLE_DIV = 4,
  parameter int               OUT_W      = 4
) (
  input  logic             CLK100MHZ,
  input  logic             CPU_RESETN,
  input  logic             en,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic [OUT_W-1:0] rnd_max,
  output logic [OUT_W-1:0] rnd,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic [7:0]       reject_cnt
);
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  logic [OUT_W-1:0] cand, rnd_d, rnd_q;
  logic [DIV_W-1:0] div_d, div_q;
  logic [7:0]       rej_d, rej_q;
  logic             valid_d, valid_q, samp, acc, load;
  lfsr_core #(.WIDTH(WIDTH), .TAPS(TAPS), .SEED(SEED), .OUT_W(OUT_W)) u_core (
    .clk(CLK100MHZ), .rst_n(CPU_RESETN), .en(en), .seed_load(seed_load), .seed(seed), .cand(cand)
  );
  // seed_load overrides everything except the reject counter, which it leaves alone
  always_comb begin
    samp    = en && div_q == DIV_LAST;
    acc     = samp && cand <= rnd_max;
    load    = !seed_load && acc && (!valid_q || rnd_ready);
    div_d   = seed_load ? '0 : en ? ((div_q == DIV_LAST) ? '0 : div_q + 1'b1) : div_q;
    rnd_d   = load ? cand : rnd_q;
    valid_d = seed_load ? 1'b0 : load ? 1'b1 : (valid_q && rnd_ready) ? 1'b0 : valid_q;
    rej_d   = (!seed_load && samp && !acc && rej_q != 8'hFF) ? rej_q + 8'd1 : rej_q;
  end
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN)
    if (!CPU_RESETN) begin
      div_q   <= '0;
      rnd_q   <= '0;
      valid_q <= 1'b0;
      rej_q   <= '0;
    end else begin
      div_q   <= div_d;
      rnd_q   <= rnd_d;
      valid_q <= valid_d;
      rej_q   <= rej_d;
    end
  assign rnd        = rnd_q;
  assign rnd_valid  = valid_q;
  assign reject_cnt = rej_q;
endmodule

// File: tb/tb_lfsr_rng.sv
// tb_lfsr_rng: directed scenarios plus a per-cycle behavioural model of lfsr_rng.
module tb_lfsr_rng;
  localparam int W = 4, DIV = 4;
  localparam logic [3:0] TAPS = 4'hC, SEED = 4'hA;
  logic clk = 0, rst_n = 0, en = 0, seed_load = 0, rnd_ready = 1, rnd_valid;
  logic [3:0] seed = 0, rnd_max = 4'hF, rnd;
  logic [7:0] reject_cnt;
  int checks = 0, errors = 0;
  logic run = 1, zap = 0;
  lfsr_rng #(.WIDTH(W), .TAPS(TAPS), .SEED(SEED), .SAMPLE_DIV(DIV), .OUT_W(W)) dut (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .en(en), .seed_load(seed_load), .seed(seed),
    .rnd_max(rnd_max), .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .reject_cnt(reject_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask
  // Model: the state sequence as a plain number, samples every DIV-th enabled cycle
  function automatic logic [3:0] lfsr_next(input logic [3:0] s);
    int ones = 0;
    if (s == 0) return SEED;
    for (int i = 0; i < W; i++) if (TAPS[i] && s[i]) ones++;
    return 4'(((int'(s) * 2) % 16) + (ones % 2));
  endfunction
  logic [3:0] m_state, m_rnd;
  logic       m_valid;
  int         m_n, m_rej;
  wire [3:0] m_cur = zap ? 4'h0 : m_state;
  wire       m_samp = en && (m_n % DIV == DIV - 1);
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_state <= SEED; m_n <= 0; m_valid <= 0; m_rnd <= 0; m_rej <= 0;
    end else if (seed_load) begin
      m_state <= (seed == 0) ? SEED : seed; m_n <= 0; m_valid <= 0;
    end else begin
      if (en) begin
        m_state <= lfsr_next(m_cur);
        m_n <= m_n + 1;
      end
      if (m_samp && m_cur > rnd_max) m_rej <= (m_rej == 255) ? 255 : m_rej + 1;
      if (m_samp && m_cur <= rnd_max && (!m_valid || rnd_ready)) begin
        m_rnd <= m_cur; m_valid <= 1;
      end else if (m_valid && rnd_ready) m_valid <= 0;
    end
  always @(negedge clk)
    if (run) begin
      chk("model_valid", rnd_valid, m_valid);
      chk("model_rnd", rnd, m_rnd);
      chk("model_rej", reject_cnt, m_rej);
      if (!zap) chk("model_state", dut.u_core.state_q, m_state);
    end
  task automatic do_reset();
    @(negedge clk); #2 rst_n = 0;
    #1 chk("rst_valid", rnd_valid, 0);
    chk("rst_rnd", rnd, 0);
    chk("rst_rej", reject_cnt, 0);
    chk("rst_state", dut.u_core.state_q, SEED);
    @(negedge clk); @(negedge clk); rst_n = 1;
  endtask
  logic [3:0] seq [8] = '{4'hA, 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
  initial begin
    // Scenario 1: full range, consumer always ready
    do_reset();
    en = 1;
    for (int k = 0; k < 8; k++) begin
      chk("s1_state", dut.u_core.state_q, seq[k]);
      chk("s1_valid", rnd_valid, k == 4);
      if (k == 4) chk("s1_rnd7", rnd, 4'h7);
      @(negedge clk);
    end
    chk("s1_valid8", rnd_valid, 1);
    chk("s1_rnd8", rnd, 4'h8);
    @(negedge clk);
    chk("s1_valid_drop", rnd_valid, 0);
    // Scenario 2: 8 is above the bound
    en = 0; rnd_max = 4'h7;
    do_reset();
    en = 1;
    repeat (10) @(negedge clk);
    chk("s2_rej", reject_cnt, 1);
    chk("s2_rnd", rnd, 4'h7);
    chk("s2_valid", rnd_valid, 0);
    // Scenario 3: consumer stalled, later samples dropped
    en = 0; rnd_max = 4'hF; rnd_ready = 0;
    do_reset();
    en = 1;
    repeat (20) @(negedge clk);
    chk("s3_valid", rnd_valid, 1);
    chk("s3_rnd", rnd, 4'h7);
    // Scenario 4: seed_load of zero falls back to SEED, clears slot
    seed = 4'h0; seed_load = 1;
    @(negedge clk);
    seed_load = 0;
    chk("s4_state", dut.u_core.state_q, 4'hA);
    chk("s4_div", dut.div_q, 0);
    chk("s4_valid", rnd_valid, 0);
    seed = 4'h3; seed_load = 1;
    @(negedge clk);
    seed_load = 0;
    chk("s4_seed3", dut.u_core.state_q, 4'h3);
    chk("s4_div3", dut.div_q, 0);
    rnd_ready = 1;
    // Scenario 5: lock-up recovery and reject saturation
    en = 0; rnd_max = 4'h0;
    do_reset();
    en = 1;
    @(negedge clk);
    zap = 1;
    force dut.u_core.state_q = 4'h0;
    #1 release dut.u_core.state_q;
    chk("s5_zero", dut.u_core.state_q, 4'h0);
    @(negedge clk);
    zap = 0;
    chk("s5_recover", dut.u_core.state_q, 4'hA);
    repeat (1220) @(negedge clk);
    chk("s5_sat", reject_cnt, 255);
    // Scenario 6: asynchronous reset with a sample pending
    en = 0; rnd_max = 4'hF; rnd_ready = 0;
    do_reset();
    en = 1;
    repeat (5) @(negedge clk);
    chk("s6_pre_valid", rnd_valid, 1);
    chk("s6_pre_rnd", rnd, 4'h7);
    #2 rst_n = 0;
    #1 chk("s6_async_valid", rnd_valid, 0);
    chk("s6_async_rnd", rnd, 0);
    @(negedge clk); rst_n = 1; rnd_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk("s6_no_pulse", rnd_valid, 0);
      @(negedge clk);
    end
    chk("s6_first", rnd_valid, 1);
    run = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
